pc_unit: RTL

- Parametrised next-generation program counter for the pipelined MIPS fetch stage.
- Selects the next fetch address from a prioritised set of redirect sources (flush, branch, jump, return), honours stall and halt, and flags misaligned targets.
- Can optionally include a return-address stack (RAS) for jal/jr $ra.
- Feeds the instruction memory address and the IF/ID pipeline register (pc, pc_plus_inc).

---
 rtl/pc_pkg.sv | 26 ++
 rtl/pc_ras.sv | 66 ++++++
 rtl/pc_unit.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared state/source types and alignment helper for the program counter unit.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

    typedef enum logic [2:0] {
        SRC_HOLD   = 3'd0,
        SRC_FLUSH  = 3'd1,
        SRC_BRANCH = 3'd2,
        SRC_JUMP   = 3'd3,
        SRC_RET    = 3'd4,
        SRC_SEQ    = 3'd5
    } pc_src_e;

    localparam int unsigned MASK_W = 64;

    // Mask of the address bits that lie below the INC alignment boundary.
    function automatic logic [MASK_W-1:0] align_mask(input int unsigned inc);
        return MASK_W'(inc) - MASK_W'(1);
    endfunction

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] top_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wp_q, wp_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    assign top_o   = mem_q[wp_q - PW'(1)];
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));

    // Pointer and occupancy update; clear wins over push/pop.
    always_comb begin
        wp_d  = wp_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            wp_d  = '0;
            cnt_d = '0;
        end else if (push_i) begin
            wp_d = wp_q + PW'(1);
            if (!full_o) begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (pop_i && !empty_o) begin
            wp_d  = wp_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Pointer/occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) begin
            mem_q[wp_q] <= data_i;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with prioritised redirects, stall and halt.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned      INC          = 4,
    parameter int unsigned      RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             halt,
    input  logic             resume,
    input  logic             flush_valid,
    input  logic [WIDTH-1:0] flush_target,
    input  logic             branch_valid,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump_valid,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus_inc,
    output logic             pc_valid,
    output logic             misalign,
    output logic             ras_underflow
);

    localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(align_mask(INC));

    pc_state_e        state_q, state_d;
    pc_src_e          src_c;
    logic             ret_miss_c;
    logic [WIDTH-1:0] pc_q, pc_d, pc_inc_c, target_c;
    logic             misalign_q, misalign_d;
    logic             ras_unf_q, ras_unf_d;
    logic [WIDTH-1:0] ras_top_c;
    logic             ras_empty_c;

    assign pc_inc_c = pc_q + WIDTH'(INC);

`ifdef PC_RAS_EN
    localparam bit RAS_EN = 1'b1;
    logic ras_full_unused;

    pc_ras #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst_n   (rst),
        .clear_i (src_c == SRC_FLUSH),
        .push_i  ((src_c == SRC_JUMP) && call),
        .pop_i   (src_c == SRC_RET),
        .data_i  (pc_inc_c),
        .top_o   (ras_top_c),
        .empty_o (ras_empty_c),
        .full_o  (ras_full_unused)
    );
`else
    localparam bit          RAS_EN           = 1'b0;
    localparam int unsigned RAS_DEPTH_UNUSED = RAS_DEPTH;
    logic call_unused;

    assign call_unused = call;
    assign ras_top_c   = '0;
    assign ras_empty_c = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and next-PC source selection; halt yields only to flush.
    always_comb begin
        state_d    = state_q;
        src_c      = SRC_HOLD;
        ret_miss_c = 1'b0;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (flush_valid) begin
                    src_c = SRC_FLUSH;
                end else if (halt) begin
                    state_d = HALT;
                end else if (stall) begin
                    src_c = SRC_HOLD;
                end else if (branch_valid) begin
                    src_c = SRC_BRANCH;
                end else if (jump_valid) begin
                    src_c = SRC_JUMP;
                end else if (ret && RAS_EN && !ras_empty_c) begin
                    src_c = SRC_RET;
                end else begin
                    src_c      = SRC_SEQ;
                    ret_miss_c = ret && RAS_EN;
                end
            end
            HALT: begin
                if (flush_valid) begin
                    src_c   = SRC_FLUSH;
                    state_d = RUN;
                end else if (resume) begin
                    src_c   = SRC_SEQ;
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // Next PC and pulse flags from the selected source; targets are forced aligned.
    always_comb begin
        pc_d       = pc_q;
        misalign_d = 1'b0;
        ras_unf_d  = ret_miss_c;
        target_c   = '0;
        case (src_c)
            SRC_FLUSH:  target_c = flush_target;
            SRC_BRANCH: target_c = branch_target;
            SRC_JUMP:   target_c = jump_target;
            default:    target_c = '0;
        endcase
        case (src_c)
            SRC_FLUSH, SRC_BRANCH, SRC_JUMP: begin
                pc_d       = target_c & ~LOW_MASK;
                misalign_d = |(target_c & LOW_MASK);
            end
            SRC_RET: pc_d = ras_top_c;
            SRC_SEQ: pc_d = pc_inc_c;
            default: pc_d = pc_q;
        endcase
    end

    // PC and flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= RESET_VECTOR;
            misalign_q <= 1'b0;
            ras_unf_q  <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
            ras_unf_q  <= ras_unf_d;
        end
    end

    // Output drive; pc_valid only while fetching in RUN.
    always_comb begin
        pc            = pc_q;
        pc_plus_inc   = pc_inc_c;
        pc_valid      = (state_q == RUN);
        misalign      = misalign_q;
        ras_underflow = ras_unf_q;
    end

endmodule
